memory_map: RTL and testbench

- Downstream of the DivMMC mapper. Takes its map/ram/page outputs plus the Z80 bus.
- Holds the 128K/+3 paging registers (ports 7FFD/1FFD) and resolves each CPU memory cycle to a 19-bit physical address in the 512KB external RAM.
- Enforces write protection on ROM and protected regions.
- Runs a req/ack handshake with the external memory controller and stretches the CPU cycle through wait_n until the access completes.

---
 rtl/memory_map.sv | 145 ++++++++++++++
 tb/tb_memory_map.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/memory_map.sv
// 128K/+3 paging registers and physical address resolution for the Z80 bus.
// Runs a req/ack handshake with the memory controller and stretches via wait_n.
module memory_map #(
    parameter bit PLUS3 = 1'b1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        ce,
    input  logic        mreq,
    input  logic        iorq,
    input  logic        rd,
    input  logic        wr,
    input  logic        rfsh,
    input  logic [15:0] a,
    input  logic [7:0]  d,
    input  logic        map,
    input  logic        ram,
    input  logic [3:0]  page,
    output logic [18:0] maddr,
    output logic        mwe,
    output logic        mreq_o,
    input  logic        mack,
    output logic        wait_n,
    output logic        vpage
);

    typedef enum logic [1:0] {IDLE, REQ, HOLD} state_t;

    state_t      state;
    state_t      state_nx;
    logic [5:0]  p7ffd;
    logic [2:0]  p1ffd;
    logic        lock;
    logic        special;
    logic        sel_7ffd;
    logic        sel_1ffd;
    logic        mem_cycle;
    logic [2:0]  sp_bank;
    logic [18:0] addr_c;
    logic        prot_c;

    assign lock      = p7ffd[5];
    assign special   = p1ffd[0];
    assign vpage     = p7ffd[3];
    assign sel_7ffd  = !iorq && !wr && !a[15] && !a[1];
    assign sel_1ffd  = PLUS3 && !iorq && !wr
                       && (a[15:12] == 4'h1) && !a[1];
    assign mem_cycle = !mreq && rfsh && (!rd || !wr);

    // Paging registers; the lock bit freezes both until reset
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            p7ffd <= 6'd0;
            p1ffd <= 3'd0;
        end else if (ce && !lock) begin
            if (sel_7ffd) p7ffd <= d[5:0];
            if (sel_1ffd) p1ffd <= d[2:0];
        end
    end

    // Bank for each 16K slot in the all-RAM special modes
    always_comb begin
        sp_bank = 3'd0;
        case (p1ffd[2:1])
            2'b00: sp_bank = {1'b0, a[15:14]};
            2'b01: sp_bank = {1'b1, a[15:14]};
            2'b10: sp_bank = (a[15:14] == 2'b11) ? 3'd3
                                                 : {1'b1, a[15:14]};
            default: begin
                if (a[15:14] == 2'b11)      sp_bank = 3'd3;
                else if (a[15:14] == 2'b01) sp_bank = 3'd7;
                else                        sp_bank = {1'b1, a[15:14]};
            end
        endcase
    end

    // Physical address and write protection; DivMMC overrides everything
    always_comb begin
        addr_c = 19'd0;
        prot_c = 1'b0;
        if (map && (a[15:14] == 2'b00)) begin
            if (!a[13] && !ram) begin
                addr_c = {6'b011000, a[12:0]};
                prot_c = 1'b1;
            end else begin
                addr_c = {2'b10, page, a[12:0]};
                prot_c = ram && (page == 4'd3);
            end
        end else if (special) begin
            addr_c = {2'b00, sp_bank, a[13:0]};
        end else begin
            case (a[15:14])
                2'b00: begin
                    addr_c = {3'b010, p1ffd[2], p7ffd[4], a[13:0]};
                    prot_c = 1'b1;
                end
                2'b01:   addr_c = {2'b00, 3'd5, a[13:0]};
                2'b10:   addr_c = {2'b00, 3'd2, a[13:0]};
                default: addr_c = {2'b00, p7ffd[2:0], a[13:0]};
            endcase
        end
    end

    // State register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    // Next state: one request per CPU memory cycle
    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (ce && mem_cycle)
                    state_nx = (!wr && prot_c) ? HOLD : REQ;
            end
            REQ: begin
                if (ce && mack) state_nx = HOLD;
            end
            HOLD: begin
                if (ce && mreq) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Address and direction captured at the start of a memory cycle
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            maddr <= 19'd0;
            mwe   <= 1'b0;
        end else if (ce && (state == IDLE) && mem_cycle) begin
            maddr <= addr_c;
            mwe   <= !wr;
        end
    end

    // Handshake outputs follow the state directly
    always_comb begin
        mreq_o = (state == REQ);
        wait_n = (state != REQ);
    end

endmodule

// File: tb/tb_memory_map.sv
// Directed testbench for memory_map (PLUS3=1).
// Each task drives one scenario and checks outputs inline.
module tb_memory_map;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        ce = 1'b1;
    logic        mreq = 1'b1;
    logic        iorq = 1'b1;
    logic        rd = 1'b1;
    logic        wr = 1'b1;
    logic        rfsh = 1'b1;
    logic [15:0] a = 16'h0;
    logic [7:0]  d = 8'h0;
    logic        map = 1'b0;
    logic        ram = 1'b0;
    logic [3:0]  page = 4'h0;
    logic [18:0] maddr;
    logic        mwe;
    logic        mreq_o;
    logic        mack = 1'b0;
    logic        wait_n;
    logic        vpage;

    int checks = 0;
    int failures = 0;

    memory_map #(.PLUS3(1'b1)) dut (
        .clock(clock), .reset(reset), .ce(ce),
        .mreq(mreq), .iorq(iorq), .rd(rd), .wr(wr), .rfsh(rfsh),
        .a(a), .d(d), .map(map), .ram(ram), .page(page),
        .maddr(maddr), .mwe(mwe), .mreq_o(mreq_o), .mack(mack),
        .wait_n(wait_n), .vpage(vpage)
    );

    always #5 clock = ~clock;

    task automatic do_reset();
        reset = 1'b1;
        mreq = 1'b1; iorq = 1'b1; rd = 1'b1; wr = 1'b1;
        rfsh = 1'b1; mack = 1'b0; ce = 1'b1;
        map = 1'b0; ram = 1'b0; page = 4'h0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic io_wr(input logic [15:0] addr, input logic [7:0] data);
        @(negedge clock);
        a = addr; d = data; iorq = 1'b0; wr = 1'b0;
        @(negedge clock);
        iorq = 1'b1; wr = 1'b1;
    endtask

    task automatic mem_go(input logic [15:0] addr, input bit w);
        @(negedge clock);
        a = addr; mreq = 1'b0;
        if (w) wr = 1'b0;
        else   rd = 1'b0;
        @(posedge clock); #1;
    endtask

    task automatic mem_ack();
        @(negedge clock);
        mack = 1'b1;
        @(posedge clock); #1;
    endtask

    task automatic mem_end();
        @(negedge clock);
        mack = 1'b0; mreq = 1'b1; rd = 1'b1; wr = 1'b1;
        @(posedge clock); #1;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        checks++; if (mreq_o !== 1'b0) begin failures++;
            $display("FAIL reset_mreq_o got %b want 0", mreq_o); end
        checks++; if (wait_n !== 1'b1) begin failures++;
            $display("FAIL reset_wait_n got %b want 1", wait_n); end
        checks++; if (maddr !== 19'h0) begin failures++;
            $display("FAIL reset_maddr got %h want 0", maddr); end
        checks++; if (mwe !== 1'b0) begin failures++;
            $display("FAIL reset_mwe got %b want 0", mwe); end
        checks++; if (vpage !== 1'b0) begin failures++;
            $display("FAIL reset_vpage got %b want 0", vpage); end
    endtask

    task automatic test_rom_read();
        mem_go(16'h0000, 1'b0);
        checks++; if (maddr !== 19'h20000) begin failures++;
            $display("FAIL rom_maddr got %h want 20000", maddr); end
        checks++; if (mreq_o !== 1'b1 || wait_n !== 1'b0) begin failures++;
            $display("FAIL rom_req got %b%b want 10", mreq_o, wait_n); end
        checks++; if (mwe !== 1'b0) begin failures++;
            $display("FAIL rom_mwe got %b want 0", mwe); end
        @(posedge clock); #1;
        checks++; if (mreq_o !== 1'b1) begin failures++;
            $display("FAIL rom_hold_req got %b want 1", mreq_o); end
        mem_ack();
        checks++; if (mreq_o !== 1'b0 || wait_n !== 1'b1) begin failures++;
            $display("FAIL rom_ack got %b%b want 01", mreq_o, wait_n); end
        mem_end();
    endtask

    task automatic test_paging();
        io_wr(16'h7FFD, 8'h13);
        #1;
        checks++; if (vpage !== 1'b0) begin failures++;
            $display("FAIL pg_vpage got %b want 0", vpage); end
        mem_go(16'hC005, 1'b0);
        checks++; if (maddr !== 19'h0C005) begin failures++;
            $display("FAIL pg_bank3 got %h want 0C005", maddr); end
        mem_ack(); mem_end();
        mem_go(16'h0000, 1'b0);
        checks++; if (maddr !== 19'h24000) begin failures++;
            $display("FAIL pg_rom1 got %h want 24000", maddr); end
        mem_ack(); mem_end();
        io_wr(16'h7FFD, 8'h08);
        #1;
        checks++; if (vpage !== 1'b1) begin failures++;
            $display("FAIL pg_vpage1 got %b want 1", vpage); end
        mem_go(16'hC005, 1'b0);
        checks++; if (maddr !== 19'h00005) begin failures++;
            $display("FAIL pg_bank0 got %h want 00005", maddr); end
        mem_ack(); mem_end();
    endtask

    task automatic test_lock();
        do_reset();
        io_wr(16'h7FFD, 8'h20);
        io_wr(16'h7FFD, 8'h0F);
        #1;
        checks++; if (vpage !== 1'b0) begin failures++;
            $display("FAIL lock_vpage got %b want 0", vpage); end
        mem_go(16'hC123, 1'b0);
        checks++; if (maddr !== 19'h00123) begin failures++;
            $display("FAIL lock_c000 got %h want 00123", maddr); end
        mem_ack(); mem_end();
        io_wr(16'h1FFD, 8'h01);
        mem_go(16'h4000, 1'b0);
        checks++; if (maddr !== 19'h14000) begin failures++;
            $display("FAIL lock_1ffd got %h want 14000", maddr); end
        mem_ack(); mem_end();
        mem_go(16'h0000, 1'b0);
        checks++; if (maddr !== 19'h20000) begin failures++;
            $display("FAIL lock_rom got %h want 20000", maddr); end
        mem_ack(); mem_end();
    endtask

    task automatic test_special();
        do_reset();
        io_wr(16'h1FFD, 8'h07);
        mem_go(16'h4000, 1'b0);
        checks++; if (maddr !== 19'h1C000) begin failures++;
            $display("FAIL sp11_4000 got %h want 1C000", maddr); end
        mem_ack(); mem_end();
        mem_go(16'h0000, 1'b1);
        checks++; if (maddr !== 19'h10000) begin failures++;
            $display("FAIL sp11_wr got %h want 10000", maddr); end
        checks++; if (mwe !== 1'b1 || mreq_o !== 1'b1) begin failures++;
            $display("FAIL sp11_mwe got %b%b want 11", mwe, mreq_o); end
        mem_ack(); mem_end();
        mem_go(16'hC010, 1'b0);
        checks++; if (maddr !== 19'h0C010) begin failures++;
            $display("FAIL sp11_c000 got %h want 0C010", maddr); end
        mem_ack(); mem_end();
        io_wr(16'h1FFD, 8'h05);
        mem_go(16'h4001, 1'b0);
        checks++; if (maddr !== 19'h14001) begin failures++;
            $display("FAIL sp10_4000 got %h want 14001", maddr); end
        mem_ack(); mem_end();
        do_reset();
        io_wr(16'h1FFD, 8'h04);
        mem_go(16'h0000, 1'b0);
        checks++; if (maddr !== 19'h28000) begin failures++;
            $display("FAIL rom_hi got %h want 28000", maddr); end
        mem_ack(); mem_end();
    endtask

    task automatic test_divmmc();
        do_reset();
        map = 1'b1; ram = 1'b0; page = 4'd5;
        mem_go(16'h0100, 1'b0);
        checks++; if (maddr !== 19'h30100) begin failures++;
            $display("FAIL esx_rd got %h want 30100", maddr); end
        mem_ack(); mem_end();
        mem_go(16'h0100, 1'b1);
        checks++; if (mreq_o !== 1'b0 || wait_n !== 1'b1) begin failures++;
            $display("FAIL esx_wr got %b%b want 01", mreq_o, wait_n); end
        mem_end();
        mem_go(16'h2100, 1'b1);
        checks++; if (maddr !== 19'h4A100 || mreq_o !== 1'b1) begin failures++;
            $display("FAIL divram_wr got %h/%b want 4A100/1", maddr, mreq_o); end
        mem_ack(); mem_end();
        mem_go(16'h4000, 1'b0);
        checks++; if (maddr !== 19'h14000) begin failures++;
            $display("FAIL div_ram5 got %h want 14000", maddr); end
        mem_ack(); mem_end();
    endtask

    task automatic test_divram_prot();
        map = 1'b1; ram = 1'b1; page = 4'd3;
        mem_go(16'h2000, 1'b1);
        checks++; if (mreq_o !== 1'b0 || wait_n !== 1'b1) begin failures++;
            $display("FAIL dr3_hi got %b%b want 01", mreq_o, wait_n); end
        mem_end();
        mem_go(16'h0000, 1'b1);
        checks++; if (mreq_o !== 1'b0) begin failures++;
            $display("FAIL dr3_lo got %b want 0", mreq_o); end
        mem_end();
        mem_go(16'h2000, 1'b0);
        checks++; if (maddr !== 19'h46000 || mreq_o !== 1'b1) begin failures++;
            $display("FAIL dr3_rd got %h/%b want 46000/1", maddr, mreq_o); end
        mem_ack(); mem_end();
        map = 1'b0; ram = 1'b0;
    endtask

    task automatic test_refresh();
        @(negedge clock);
        a = 16'h4000; mreq = 1'b0; rd = 1'b0; rfsh = 1'b0;
        @(posedge clock); #1;
        checks++; if (mreq_o !== 1'b0 || wait_n !== 1'b1) begin failures++;
            $display("FAIL refresh got %b%b want 01", mreq_o, wait_n); end
        @(negedge clock);
        mreq = 1'b1; rd = 1'b1; rfsh = 1'b1;
    endtask

    task automatic test_ce();
        @(negedge clock);
        ce = 1'b0;
        a = 16'h8000; mreq = 1'b0; rd = 1'b0;
        @(posedge clock); #1;
        checks++; if (mreq_o !== 1'b0) begin failures++;
            $display("FAIL ce_low got %b want 0", mreq_o); end
        @(negedge clock);
        ce = 1'b1;
        @(posedge clock); #1;
        checks++; if (mreq_o !== 1'b1 || maddr !== 19'h08000) begin failures++;
            $display("FAIL ce_high got %b/%h want 1/08000", mreq_o, maddr); end
        mem_ack(); mem_end();
    endtask

    task automatic test_back_to_back();
        mem_go(16'h8001, 1'b0);
        mem_ack();
        @(negedge clock);
        mack = 1'b0;
        repeat (2) @(posedge clock); #1;
        checks++; if (mreq_o !== 1'b0 || wait_n !== 1'b1) begin failures++;
            $display("FAIL one_req got %b%b want 01", mreq_o, wait_n); end
        mem_ack();
        checks++; if (mreq_o !== 1'b0) begin failures++;
            $display("FAIL hold_mack got %b want 0", mreq_o); end
        mem_end();
        mem_go(16'h8002, 1'b0);
        checks++; if (mreq_o !== 1'b1 || maddr !== 19'h08002) begin failures++;
            $display("FAIL next_req got %b/%h want 1/08002", mreq_o, maddr); end
        mem_ack(); mem_end();
    endtask

    task automatic test_reset_mid_req();
        mem_go(16'h4000, 1'b0);
        #1;
        reset = 1'b1;
        #1;
        checks++; if (mreq_o !== 1'b0 || wait_n !== 1'b1) begin failures++;
            $display("FAIL rst_mid got %b%b want 01", mreq_o, wait_n); end
        @(negedge clock);
        mreq = 1'b1; rd = 1'b1;
        reset = 1'b0;
        @(posedge clock); #1;
        checks++; if (mreq_o !== 1'b0 || maddr !== 19'h0) begin failures++;
            $display("FAIL rst_after got %b/%h want 0/00000", mreq_o, maddr); end
    endtask

    initial begin
        test_reset();
        test_rom_read();
        test_paging();
        test_lock();
        test_special();
        test_divmmc();
        test_divram_prot();
        test_refresh();
        test_ce();
        test_back_to_back();
        test_reset_mid_req();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
